// File: rtl/pong_pkg.sv
// Shared definitions for the Pong match controller.
//   state_t            : match state encoding driven on the controller's state output
//   SERVE_LEFT/RIGHT   : serve direction values
//   WINNER_*           : winner output values
package pong_pkg;

    typedef enum logic [2:0] {
        ATTRACT   = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        PAUSED    = 3'd3,
        POINT     = 3'd4,
        GAME_OVER = 3'd5
    } state_t;

    localparam logic SERVE_LEFT  = 1'b0;
    localparam logic SERVE_RIGHT = 1'b1;

    localparam logic [1:0] WINNER_NONE  = 2'd0;
    localparam logic [1:0] WINNER_LEFT  = 2'd1;
    localparam logic [1:0] WINNER_RIGHT = 2'd2;

endpackage

// File: rtl/rise_edge_detector.sv
// Rising-edge detector for a debounced button level.
//   clock  : system clock
//   reset  : synchronous active-high reset; history resets to 1 so a button
//            already held through reset never yields a press
//   level  : debounced button level
//   press  : one-cycle pulse on the cycle the level is first seen high
module rise_edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic press
);

    logic r_hist;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hist <= 1'b1;
        end else begin
            r_hist <= level;
        end
    end

    assign press = level & ~r_hist;

endmodule

// File: rtl/pong_match_controller.sv
// Pong match sequencer: attract, serve countdown, live play, pause,
// point hold-off and game over. Times delays in video frames.
//   clock, reset          : system clock, synchronous active-high reset
//   frame_tick            : one-cycle pulse per video frame
//   start_button          : debounced start level
//   pause_button          : debounced pause level
//   goal_left/goal_right  : one-cycle goal pulses (right / left player scores)
//   state                 : current match state (pong_pkg::state_t encoding)
//   ball_enable           : ball may move (PLAY only)
//   ball_reset            : hold ball at centre
//   serve_dir             : next serve direction (0 left, 1 right)
//   score_left/score_right: player scores, saturating at WIN_SCORE
//   winner                : 0 none, 1 left, 2 right
module pong_match_controller
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = 7,
    parameter int SCORE_W     = 4,
    parameter int SERVE_DELAY = 60,
    parameter int POINT_DELAY = 90,
    parameter int CNT_W       = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start_button,
    input  logic               pause_button,
    input  logic               goal_left,
    input  logic               goal_right,
    output logic [2:0]         state,
    output logic               ball_enable,
    output logic               ball_reset,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic [1:0]         winner
);

    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_DELAY - 1);
    localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_DELAY - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [SCORE_W-1:0] r_score_left;
    logic [SCORE_W-1:0] r_score_right;
    logic               r_serve_dir;
    logic [1:0]         r_winner;

    logic w_start_press;
    logic w_pause_press;
    logic w_serve_done;
    logic w_point_done;

    // Scores stop at the winning value rather than wrapping.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        if (s >= WIN_VAL) begin
            return s;
        end
        return s + 1'b1;
    endfunction

    rise_edge_detector u_start_edge (
        .clock (clock),
        .reset (reset),
        .level (start_button),
        .press (w_start_press)
    );

    rise_edge_detector u_pause_edge (
        .clock (clock),
        .reset (reset),
        .level (pause_button),
        .press (w_pause_press)
    );

    // The delay counter is shared by SERVE and POINT; it is zeroed on every
    // transition so each delay starts counting from zero.
    assign w_serve_done = frame_tick && (r_cnt == SERVE_LAST);
    assign w_point_done = frame_tick && (r_cnt == POINT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ATTRACT;
            r_cnt         <= '0;
            r_score_left  <= '0;
            r_score_right <= '0;
            r_serve_dir   <= SERVE_LEFT;
            r_winner      <= WINNER_NONE;
        end else begin
            case (r_state)
                ATTRACT: begin
                    // Start wins over a simultaneous pause press, which is ignored here.
                    if (w_start_press) begin
                        r_state       <= SERVE;
                        r_cnt         <= '0;
                        r_score_left  <= '0;
                        r_score_right <= '0;
                        r_serve_dir   <= SERVE_LEFT;
                        r_winner      <= WINNER_NONE;
                    end
                end

                SERVE: begin
                    if (w_serve_done) begin
                        r_state <= PLAY;
                        r_cnt   <= '0;
                    end else if (frame_tick) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                PLAY: begin
                    // A goal outranks a pause press in the same cycle.
                    if (goal_left || goal_right) begin
                        if (goal_left && !goal_right) begin
                            r_score_right <= sat_inc(r_score_right);
                            r_serve_dir   <= SERVE_LEFT;
                        end else if (goal_right && !goal_left) begin
                            r_score_left <= sat_inc(r_score_left);
                            r_serve_dir  <= SERVE_RIGHT;
                        end
                        r_state <= POINT;
                        r_cnt   <= '0;
                    end else if (w_pause_press) begin
                        r_state <= PAUSED;
                        r_cnt   <= '0;
                    end
                end

                PAUSED: begin
                    if (w_pause_press) begin
                        r_state <= PLAY;
                        r_cnt   <= '0;
                    end
                end

                POINT: begin
                    if (w_point_done) begin
                        r_cnt <= '0;
                        if (r_score_left == WIN_VAL) begin
                            r_state  <= GAME_OVER;
                            r_winner <= WINNER_LEFT;
                        end else if (r_score_right == WIN_VAL) begin
                            r_state  <= GAME_OVER;
                            r_winner <= WINNER_RIGHT;
                        end else begin
                            r_state <= SERVE;
                        end
                    end else if (frame_tick) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                GAME_OVER: begin
                    // Scores and winner stay visible until the next match starts.
                    if (w_start_press) begin
                        r_state <= ATTRACT;
                        r_cnt   <= '0;
                    end
                end

                default: begin
                    r_state <= ATTRACT;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign state       = r_state;
    assign ball_enable = (r_state == PLAY);
    assign ball_reset  = (r_state != PLAY) && (r_state != PAUSED);
    assign serve_dir   = r_serve_dir;
    assign score_left  = r_score_left;
    assign score_right = r_score_right;
    assign winner      = r_winner;

endmodule

// File: tb/tb_pong_match_controller.sv
module tb_pong_match_controller;

    localparam int WIN_SCORE   = 2;
    localparam int SCORE_W     = 4;
    localparam int SERVE_DELAY = 3;
    localparam int POINT_DELAY = 4;
    localparam int CNT_W       = 8;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               frame_tick = 1'b0;
    logic               start_button = 1'b0;
    logic               pause_button = 1'b0;
    logic               goal_left = 1'b0;
    logic               goal_right = 1'b0;
    logic [2:0]         state;
    logic               ball_enable;
    logic               ball_reset;
    logic               serve_dir;
    logic [SCORE_W-1:0] score_left;
    logic [SCORE_W-1:0] score_right;
    logic [1:0]         winner;

    int checks = 0;
    int errors = 0;

    // Reference model: match phase number, scores and frames left in the current delay.
    int m_state, m_sl, m_sr, m_dir, m_win, m_remain, m_sprev, m_pprev;

    pong_match_controller #(
        .WIN_SCORE   (WIN_SCORE),
        .SCORE_W     (SCORE_W),
        .SERVE_DELAY (SERVE_DELAY),
        .POINT_DELAY (POINT_DELAY),
        .CNT_W       (CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .start_button (start_button),
        .pause_button (pause_button),
        .goal_left    (goal_left),
        .goal_right   (goal_right),
        .state        (state),
        .ball_enable  (ball_enable),
        .ball_reset   (ball_reset),
        .serve_dir    (serve_dir),
        .score_left   (score_left),
        .score_right  (score_right),
        .winner       (winner)
    );

    always #5 clock = ~clock;

    task automatic model_step();
        int sp, pp;
        if (reset === 1'b1) begin
            m_state = 0; m_sl = 0; m_sr = 0; m_dir = 0; m_win = 0;
            m_remain = 0; m_sprev = 1; m_pprev = 1;
            return;
        end
        sp = (start_button === 1'b1 && m_sprev == 0) ? 1 : 0;
        pp = (pause_button === 1'b1 && m_pprev == 0) ? 1 : 0;
        m_sprev = (start_button === 1'b1) ? 1 : 0;
        m_pprev = (pause_button === 1'b1) ? 1 : 0;
        case (m_state)
            0: if (sp == 1) begin
                m_state = 1; m_remain = SERVE_DELAY;
                m_sl = 0; m_sr = 0; m_dir = 0; m_win = 0;
            end
            1: if (frame_tick === 1'b1) begin
                m_remain = m_remain - 1;
                if (m_remain == 0) m_state = 2;
            end
            2: if (goal_left === 1'b1 || goal_right === 1'b1) begin
                if (goal_left === 1'b1 && goal_right !== 1'b1) begin
                    m_sr = (m_sr + 1 > WIN_SCORE) ? WIN_SCORE : m_sr + 1;
                    m_dir = 0;
                end else if (goal_right === 1'b1 && goal_left !== 1'b1) begin
                    m_sl = (m_sl + 1 > WIN_SCORE) ? WIN_SCORE : m_sl + 1;
                    m_dir = 1;
                end
                m_state = 4; m_remain = POINT_DELAY;
            end else if (pp == 1) begin
                m_state = 3;
            end
            3: if (pp == 1) m_state = 2;
            4: if (frame_tick === 1'b1) begin
                m_remain = m_remain - 1;
                if (m_remain == 0) begin
                    if (m_sl == WIN_SCORE) begin m_state = 5; m_win = 1; end
                    else if (m_sr == WIN_SCORE) begin m_state = 5; m_win = 2; end
                    else begin m_state = 1; m_remain = SERVE_DELAY; end
                end
            end
            5: if (sp == 1) m_state = 0;
            default: m_state = 0;
        endcase
    endtask

    // Apply one cycle of inputs, advance the model on the edge, sample 1 time unit later.
    task automatic drive(input logic tick, input logic gl, input logic gr);
        frame_tick = tick;
        goal_left  = gl;
        goal_right = gr;
        @(posedge clock);
        model_step();
        #1;
        frame_tick = 1'b0;
        goal_left  = 1'b0;
        goal_right = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1; start_button = 1'b1;
        drive(0, 0, 0); drive(0, 0, 0);
        reset = 1'b0;
        drive(0, 0, 0); drive(0, 0, 0); drive(0, 0, 0);
        checks++;
        if (state !== 3'd0) begin errors++; $display("FAIL reset_held_state got=%0d exp=0", state); end
        checks++;
        if (score_left !== 0 || score_right !== 0) begin
            errors++; $display("FAIL reset_scores got=%0d/%0d exp=0/0", score_left, score_right);
        end
        checks++;
        if (serve_dir !== 1'b0 || winner !== 2'd0) begin
            errors++; $display("FAIL reset_dir_winner got=%0d/%0d exp=0/0", serve_dir, winner);
        end
        checks++;
        if (ball_reset !== 1'b1 || ball_enable !== 1'b0) begin
            errors++; $display("FAIL reset_ball got=%0d/%0d exp=1/0", ball_reset, ball_enable);
        end
        start_button = 1'b0; drive(0, 0, 0);
        start_button = 1'b1; pause_button = 1'b1; drive(0, 0, 0);
        checks++;
        if (state !== 3'd1 || ball_reset !== 1'b1) begin
            errors++; $display("FAIL start_to_serve got=%0d/%0d exp=1/1", state, ball_reset);
        end
        start_button = 1'b0; pause_button = 1'b0;
    endtask

    task automatic test_serve();
        drive(0, 0, 0);
        drive(1, 0, 0);
        drive(0, 1, 1);
        drive(1, 0, 0);
        checks++;
        if (state !== 3'd1) begin errors++; $display("FAIL serve_early got=%0d exp=1", state); end
        drive(1, 0, 0);
        checks++;
        if (state !== 3'd2 || ball_enable !== 1'b1 || ball_reset !== 1'b0) begin
            errors++; $display("FAIL serve_expiry got=%0d/%0d/%0d exp=2/1/0", state, ball_enable, ball_reset);
        end
        checks++;
        if (score_left !== 0 || score_right !== 0) begin
            errors++; $display("FAIL serve_goal_ignored got=%0d/%0d exp=0/0", score_left, score_right);
        end
    endtask

    task automatic test_goal_left();
        drive(0, 1, 0);
        checks++;
        if (state !== 3'd4 || score_right !== 1 || serve_dir !== 1'b0) begin
            errors++; $display("FAIL goal_left got=%0d/%0d/%0d exp=4/1/0", state, score_right, serve_dir);
        end
        ticks(POINT_DELAY - 1);
        checks++;
        if (state !== 3'd4) begin errors++; $display("FAIL point_early got=%0d exp=4", state); end
        ticks(1);
        checks++;
        if (state !== 3'd1) begin errors++; $display("FAIL point_to_serve got=%0d exp=1", state); end
        ticks(SERVE_DELAY);
    endtask

    task automatic test_both_goals();
        drive(0, 1, 1);
        checks++;
        if (state !== 3'd4 || score_left !== 0 || score_right !== 1 || serve_dir !== 1'b0) begin
            errors++; $display("FAIL both_goals got=%0d/%0d/%0d/%0d exp=4/0/1/0", state, score_left, score_right, serve_dir);
        end
        ticks(POINT_DELAY);
        ticks(SERVE_DELAY);
    endtask

    task automatic test_goal_and_pause();
        pause_button = 1'b1;
        drive(0, 0, 1);
        checks++;
        if (state !== 3'd4 || score_left !== 1 || serve_dir !== 1'b1) begin
            errors++; $display("FAIL goal_beats_pause got=%0d/%0d/%0d exp=4/1/1", state, score_left, serve_dir);
        end
        pause_button = 1'b0;
        ticks(POINT_DELAY);
        ticks(SERVE_DELAY);
        checks++;
        if (state !== 3'd2) begin errors++; $display("FAIL back_to_play got=%0d exp=2", state); end
    endtask

    task automatic test_pause();
        pause_button = 1'b1; drive(0, 0, 0);
        checks++;
        if (state !== 3'd3 || ball_enable !== 1'b0 || ball_reset !== 1'b0) begin
            errors++; $display("FAIL pause_enter got=%0d/%0d/%0d exp=3/0/0", state, ball_enable, ball_reset);
        end
        pause_button = 1'b0; drive(0, 0, 0);
        start_button = 1'b1; drive(0, 0, 0);
        start_button = 1'b0; drive(0, 1, 0);
        checks++;
        if (state !== 3'd3 || score_right !== 1) begin
            errors++; $display("FAIL paused_ignores got=%0d/%0d exp=3/1", state, score_right);
        end
        pause_button = 1'b1; drive(0, 0, 0);
        checks++;
        if (state !== 3'd2 || ball_enable !== 1'b1) begin
            errors++; $display("FAIL pause_resume got=%0d/%0d exp=2/1", state, ball_enable);
        end
        pause_button = 1'b0; drive(0, 0, 0);
    endtask

    task automatic test_win();
        drive(0, 0, 1);
        ticks(POINT_DELAY);
        checks++;
        if (state !== 3'd5 || winner !== 2'd1 || score_left !== 2) begin
            errors++; $display("FAIL game_over got=%0d/%0d/%0d exp=5/1/2", state, winner, score_left);
        end
        ticks(3); drive(0, 1, 0);
        checks++;
        if (state !== 3'd5 || score_right !== 1) begin
            errors++; $display("FAIL game_over_hold got=%0d/%0d exp=5/1", state, score_right);
        end
        start_button = 1'b1; drive(0, 0, 0);
        checks++;
        if (state !== 3'd0) begin errors++; $display("FAIL over_to_attract got=%0d exp=0", state); end
        start_button = 1'b0; drive(0, 0, 0);
        start_button = 1'b1; drive(0, 0, 0);
        checks++;
        if (state !== 3'd1 || score_left !== 0 || score_right !== 0 || winner !== 2'd0) begin
            errors++; $display("FAIL new_match got=%0d/%0d/%0d/%0d exp=1/0/0/0", state, score_left, score_right, winner);
        end
        start_button = 1'b0; drive(0, 0, 0);
    endtask

    task automatic test_random();
        logic tk, gl, gr;
        int exp_be, exp_br;
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 5) == 0) start_button = ~start_button;
            if ($urandom_range(0, 5) == 0) pause_button = ~pause_button;
            tk = ($urandom_range(0, 1) == 0);
            gl = ($urandom_range(0, 7) == 0);
            gr = ($urandom_range(0, 7) == 0);
            drive(tk, gl, gr);
            exp_be = (m_state == 2) ? 1 : 0;
            exp_br = (m_state == 2 || m_state == 3) ? 0 : 1;
            checks++;
            if (state !== 3'(m_state) || score_left !== SCORE_W'(m_sl) || score_right !== SCORE_W'(m_sr)
                || serve_dir !== 1'(m_dir) || winner !== 2'(m_win)
                || ball_enable !== 1'(exp_be) || ball_reset !== 1'(exp_br)) begin
                errors++;
                $display("FAIL random cyc=%0d got st=%0d sl=%0d sr=%0d dir=%0d win=%0d be=%0d br=%0d exp st=%0d sl=%0d sr=%0d dir=%0d win=%0d be=%0d br=%0d",
                         i, state, score_left, score_right, serve_dir, winner, ball_enable, ball_reset,
                         m_state, m_sl, m_sr, m_dir, m_win, exp_be, exp_br);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_serve();
        test_goal_left();
        test_both_goals();
        test_goal_and_pause();
        test_pause();
        test_win();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pong_match_controller.md
Name: pong_match_controller

Overview:
Sequences a Pong match from debounced player buttons and ball-goal events: attract, serve countdown, live play, pause, point hold-off and game over. It sits between the button debouncers and the ball/paddle datapath, gating ball motion, requesting ball re-centring and keeping both scores. All timing is counted in video frames via a one-cycle frame tick.

Parameters:
WIN_SCORE, 7, points needed to win; must be < 2^SCORE_W
SCORE_W, 4, width of each score counter
SERVE_DELAY, 60, frame ticks the ball is held at centre before play; >= 1
POINT_DELAY, 90, frame ticks of hold-off after a goal; >= 1
CNT_W, 8, width of the shared frame-delay counter; must hold max(SERVE_DELAY, POINT_DELAY)-1

Ports:
clock  input  1  system clock; the only clock
reset  input  1  synchronous, active-high reset
frame_tick  input  1  one-cycle pulse per video frame
start_button  input  1  debounced start level
pause_button  input  1  debounced pause level
goal_left  input  1  one-cycle pulse: ball passed the left edge, so the right player scores
goal_right  input  1  one-cycle pulse: ball passed the right edge, so the left player scores
state  output  3  current match state (package encoding)
ball_enable  output  1  ball may move
ball_reset  output  1  hold ball at centre
serve_dir  output  1  0 = next serve toward left player, 1 = toward right player
score_left  output  SCORE_W  left player score
score_right  output  SCORE_W  right player score
winner  output  2  0 = none, 1 = left, 2 = right

Behaviour:
- Reset (clock edge with reset=1): state=ATTRACT; scores=0; serve_dir=0; winner=0; delay counter=0; both button-history registers=1.
- Because the history registers reset to 1, a button held through reset produces no press.
- Press detection: press = level & ~history; history <= level every cycle. The state reacts on the same edge that samples the rising level (1-cycle latency from input to state).
- Outputs are a Moore decode of the state register:
  - ball_enable=1 only in PLAY.
  - ball_reset=1 in ATTRACT, SERVE, POINT and GAME_OVER; 0 in PLAY and PAUSED.
- Delay counter: cleared on every state transition; increments on frame_tick only in SERVE and POINT. The expiry condition is frame_tick && counter == DELAY-1.
- ATTRACT:
  - start press -> SERVE; scores cleared, serve_dir=0, winner=0.
  - A pause press is ignored, including when start and pause rise in the same cycle (start wins).
- SERVE: on SERVE_DELAY expiry -> PLAY. Presses and goals are ignored.
- PLAY:
  - goal_left only: score_right+1; serve_dir=0; -> POINT.
  - goal_right only: score_left+1; serve_dir=1; -> POINT.
  - Both goals in the same cycle: no score change, serve_dir unchanged, -> POINT.
  - A goal outranks a simultaneous pause press; the press is discarded.
  - pause press with no goal -> PAUSED.
- PAUSED:
  - pause press -> PLAY; ball state is not reset.
  - Start presses and goals are ignored.
- POINT: on POINT_DELAY expiry:
  - if score_left == WIN_SCORE -> GAME_OVER with winner=1;
  - else if score_right == WIN_SCORE -> GAME_OVER with winner=2;
  - else -> SERVE.
- GAME_OVER: scores and winner are held; start press -> ATTRACT.
- Scores never exceed WIN_SCORE (increment saturates); no wrap-around.
- Goals, presses and frame ticks outside the states listed above are ignored.
- Reset asserted mid-match overrides all events that cycle.

Decomposition:
- Shared package pong_pkg:
  - state encodings ATTRACT=0, SERVE=1, PLAY=2, PAUSED=3, POINT=4, GAME_OVER=5;
  - SERVE_LEFT=0, SERVE_RIGHT=1;
  - WINNER_NONE=0, WINNER_LEFT=1, WINNER_RIGHT=2.
- One sub-module, rise_edge_detector: history register with synchronous reset value 1, one-cycle press output. Instantiated twice (start, pause).

Test Plan:
- Reset with start_button held high, then keep it high -> state stays ATTRACT (0), no press. Release and press again -> state=SERVE (1) on the next edge; ball_reset=1.
- SERVE_DELAY=3: from SERVE, give 3 frame_ticks -> state=PLAY (2) on the edge of the 3rd tick; ball_enable=1, ball_reset=0.
- In PLAY, pulse goal_left -> score_right=1, serve_dir=0, state=POINT (4). After POINT_DELAY ticks -> state=SERVE (1).
- In PLAY, pulse goal_left and goal_right together -> scores unchanged, state=POINT (4). In PLAY, goal_right plus a pause press in the same cycle -> score_left+1, state=POINT (4), not PAUSED.
- In PLAY, pause press -> PAUSED (3), ball_enable=0. Start press -> stays PAUSED (3). Pause press -> PLAY (2).
- WIN_SCORE=2: left scores twice -> after POINT_DELAY, state=GAME_OVER (5), winner=1, score_left=2. Start press -> ATTRACT (0). Next start press -> SERVE (1) with scores 0 and winner=0.
